// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port synchronous RAM with byte-lane writes, registered reads,
// an out-of-range error strobe and a clear engine that zeroes the array after reset or on request.
module ram_sdp_be_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              clr_we;
  logic              wr_oor, rd_oor;
  logic              wr_ok, rd_req, wr_hit;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR && clr_cnt != LAST_ADDR) clr_cnt <= clr_cnt + 1'b1;
      else                                        clr_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clr_cnt == LAST_ADDR) state_next = IDLE;
      IDLE:  if (clr_req)              state_next = CLEAR;
    endcase
  end

  always_comb begin
    idle   = (state == IDLE);
    clr_we = (state == CLEAR);
    busy   = (state == CLEAR);
  end

  always_comb begin
    wr_oor = ({1'b0, wr_addr} >= DEPTH_X);
    rd_oor = ({1'b0, rd_addr} >= DEPTH_X);
    wr_ok  = idle && cs && wr_en && !wr_oor;
    rd_req = idle && cs && rd_en;
    wr_hit = wr_ok && (wr_addr == rd_addr);
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < BE_W; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write-first bypass: a same-address write merges its enabled lanes into the read word
  always_comb begin
    rd_word = rd_oor ? '0 : mem[rd_addr];
    if (wr_hit) begin
      for (int i = 0; i < BE_W; i++)
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      addr_err <= idle && cs && ((wr_en && wr_oor) || (rd_en && rd_oor));
      if (rd_req) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Directed bench for ram_sdp_be_clr: an 8-bit x 1024 instance and a 16-bit x 12 instance
// driven through a linear sequence of steps with hand-computed expectations.
module tb_ram_sdp_be_clr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_cs = 1'b1, a_wr_en = 1'b0, a_rd_en = 1'b0, a_clr_req = 1'b0;
  logic [9:0] a_wr_addr = '0, a_rd_addr = '0;
  logic [7:0] a_wr_data = '0, a_rd_data;
  logic [0:0] a_wr_be = 1'b1;
  logic       a_rd_valid, a_addr_err, a_busy;

  logic        b_cs = 1'b1, b_wr_en = 1'b0, b_rd_en = 1'b0, b_clr_req = 1'b0;
  logic [3:0]  b_wr_addr = '0, b_rd_addr = '0;
  logic [15:0] b_wr_data = '0, b_rd_data;
  logic [1:0]  b_wr_be = 2'b11;
  logic        b_rd_valid, b_addr_err, b_busy;

  int errors = 0;
  int checks = 0;

  ram_sdp_be_clr dut_a (
    .clk(clk), .rst_n(rst_n), .cs(a_cs),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .addr_err(a_addr_err), .clr_req(a_clr_req), .busy(a_busy)
  );

  ram_sdp_be_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(b_cs),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .addr_err(b_addr_err), .clr_req(b_clr_req), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [9:0] addr, input logic [7:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = 1'b1;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [9:0] addr, input logic [7:0] exp);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick();
    check_output({tag, "_valid"}, a_rd_valid, 1);
    check_output({tag, "_data"}, a_rd_data, exp);
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic b_read(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    b_rd_en = 1'b1; b_rd_addr = addr;
    tick();
    b_rd_en = 1'b0;
    check_output({tag, "_valid"}, b_rd_valid, 1);
    check_output({tag, "_data"}, b_rd_data, exp);
  endtask

  // Counts cycles with busy high, bounded so a stuck engine still reaches the summary
  task automatic count_busy(output int n);
    n = 0;
    while (a_busy && n < 3000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int stray;

    // Reset state
    tick(); tick();
    check_output("rst_rd_data", a_rd_data, 0);
    check_output("rst_rd_valid", a_rd_valid, 0);
    check_output("rst_addr_err", a_addr_err, 0);
    check_output("rst_busy", a_busy, 1);

    // Post-reset clear lasts exactly DEPTH cycles
    #2 rst_n = 1'b1;
    count_busy(n);
    check_output("boot_busy_cycles", n, 1024);
    check_output("b_busy_done", b_busy, 0);
    a_read("boot_rd0", 10'd0, 8'h00);
    a_read("boot_rd1", 10'd1, 8'h00);
    a_read("boot_rd1023", 10'd1023, 8'h00);
    a_rd_en = 1'b0;
    tick();
    check_output("idle_rd_valid", a_rd_valid, 0);

    // Back-to-back writes then back-to-back reads
    a_write(10'd0, 8'h01);
    a_write(10'd1, 8'h12);
    a_write(10'd2, 8'h13);
    a_write(10'd3, 8'h16);
    a_write(10'd4, 8'h02);
    a_read("seq_rd0", 10'd0, 8'h01);
    a_read("seq_rd1", 10'd1, 8'h12);
    a_read("seq_rd2", 10'd2, 8'h13);
    a_read("seq_rd3", 10'd3, 8'h16);
    a_read("seq_rd4", 10'd4, 8'h02);
    a_rd_en = 1'b0;
    tick();
    check_output("hold_valid", a_rd_valid, 0);
    check_output("hold_data", a_rd_data, 8'h02);

    // Chip select low blocks access
    a_cs = 1'b0; a_rd_en = 1'b1; a_rd_addr = 10'd1;
    tick();
    check_output("cs0_valid", a_rd_valid, 0);
    check_output("cs0_data", a_rd_data, 8'h02);
    a_cs = 1'b1; a_rd_en = 1'b0;

    // Byte-lane merges on the 16-bit instance
    b_write(4'd5, 16'hABCD, 2'b11);
    b_write(4'd5, 16'h1234, 2'b01);
    b_read("be_rd5", 4'd5, 16'hAB34);
    b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 16'hFFFF; b_wr_be = 2'b10;
    b_rd_en = 1'b1; b_rd_addr = 4'd5;
    tick();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    check_output("rdw_valid", b_rd_valid, 1);
    check_output("rdw_data", b_rd_data, 16'hFF34);
    check_output("rdw_err", b_addr_err, 0);
    b_read("rdw_after", 4'd5, 16'hFF34);

    // Out-of-range accesses on the 12-deep instance
    b_write(4'd13, 16'h0055, 2'b11);
    check_output("oor_wr_err", b_addr_err, 1);
    check_output("oor_wr_valid", b_rd_valid, 0);
    tick();
    check_output("oor_err_clears", b_addr_err, 0);
    b_read("oor_rd12", 4'd12, 16'h0000);
    check_output("oor_rd_err", b_addr_err, 1);
    b_read("oor_nowrap1", 4'd1, 16'h0000);
    check_output("inrange_err", b_addr_err, 0);
    b_read("oor_keep5", 4'd5, 16'hFF34);
    b_wr_en = 1'b1; b_wr_addr = 4'd14; b_rd_en = 1'b1; b_rd_addr = 4'd15;
    tick();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    check_output("oor_both_err", b_addr_err, 1);
    tick();
    check_output("oor_both_single", b_addr_err, 0);

    // Clear request alongside a write; accesses ignored while busy
    for (int i = 0; i < 4; i++) a_write(10'(i), 8'hA5);
    a_read("fill_rd3", 10'd3, 8'hA5);
    a_clr_req = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 10'd6; a_wr_data = 8'h77;
    a_rd_en = 1'b1; a_rd_addr = 10'd6;
    tick();
    a_clr_req = 1'b0; a_wr_en = 1'b0; a_rd_addr = 10'd0;
    check_output("clr_rise_busy", a_busy, 1);
    check_output("clr_same_cycle_rd", a_rd_data, 8'h77);
    n = 0; stray = 0;
    while (a_busy && n < 3000) begin
      n++;
      a_clr_req = (n == 100);
      a_wr_en = 1'b1; a_wr_addr = 10'd2; a_wr_data = 8'hEE;
      tick();
      if (a_rd_valid !== 1'b0) stray++;
    end
    a_clr_req = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    check_output("clr_busy_cycles", n, 1024);
    check_output("clr_no_valid", stray, 0);
    check_output("clr_hold_data", a_rd_data, 8'h77);
    a_read("clr_rd0", 10'd0, 8'h00);
    a_read("clr_rd1", 10'd1, 8'h00);
    a_read("clr_rd2", 10'd2, 8'h00);
    a_read("clr_rd3", 10'd3, 8'h00);
    a_read("clr_rd6", 10'd6, 8'h00);
    a_rd_en = 1'b0;

    // Reset asserted right after a read
    a_write(10'd7, 8'h3C);
    a_read("pre_rst_rd7", 10'd7, 8'h3C);
    a_rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid_valid", a_rd_valid, 0);
    check_output("rst_mid_data", a_rd_data, 0);
    check_output("rst_mid_busy", a_busy, 1);
    rst_n = 1'b1;
    count_busy(n);
    check_output("rst_mid_busy_cycles", n, 1024);

    // Reset asserted mid-clear restarts the full sweep
    a_write(10'd8, 8'h5A);
    a_read("pre_clr_rd8", 10'd8, 8'h5A);
    a_rd_en = 1'b0;
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    check_output("mid_clr_busy", a_busy, 1);
    check_output("mid_clr_hold", a_rd_data, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_clr_data", a_rd_data, 0);
    check_output("rst_clr_busy", a_busy, 1);
    rst_n = 1'b1;
    count_busy(n);
    check_output("rst_clr_busy_cycles", n, 1024);
    a_read("final_rd8", 10'd8, 8'h00);
    a_rd_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
